// File: rtl/proc_pkg.sv
// Shared processor constants and the multiply-pipe stage record.
// Used by mul_pipe and mul_acc_stage; see mul_pipe.sv for the MUL_EARLY_FWD_EN build option.
package proc_pkg;
  localparam int ARCH_BITS    = 32;
  localparam int REG_IDX_BITS = 5;
  localparam int MUL_STAGES   = 5;
  localparam int SLICE_BITS   = ARCH_BITS / 4;

  typedef struct packed {
    logic                    valid;
    logic [REG_IDX_BITS-1:0] dst;
    logic [ARCH_BITS-1:0]    a;
    logic [ARCH_BITS-1:0]    b;
    logic [ARCH_BITS-1:0]    acc;
  } mul_stage_t;
endpackage

// File: rtl/mul_acc_stage.sv
// One accumulate stage of the multiply pipe: adds a * (slice SLICE_IDX of b), shifted into place.
// With MUL_EARLY_FWD_EN defined the accumulator already holds the full product and is passed through.
module mul_acc_stage
  import proc_pkg::*;
#(
  parameter int SLICE_IDX = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  logic       i_advance,
  input  mul_stage_t i_prev,
  output mul_stage_t o_stage
);

  mul_stage_t           r_stage;
  logic [ARCH_BITS-1:0] w_acc_next;

`ifdef MUL_EARLY_FWD_EN
  assign w_acc_next = i_prev.acc;
`else
  logic [SLICE_BITS-1:0] w_slice;
  logic [ARCH_BITS-1:0]  w_part;

  assign w_slice    = i_prev.b[SLICE_IDX*SLICE_BITS-1 -: SLICE_BITS];
  // Product is truncated to ARCH_BITS before and after the shift; only the low word survives anyway.
  assign w_part     = (i_prev.a * {{(ARCH_BITS-SLICE_BITS){1'b0}}, w_slice}) << ((SLICE_IDX-1)*SLICE_BITS);
  assign w_acc_next = i_prev.acc + w_part;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
    end else if (i_flush) begin
      r_stage.valid <= 1'b0;
    end else if (i_advance) begin
      r_stage.valid <= i_prev.valid;
      r_stage.dst   <= i_prev.dst;
      r_stage.a     <= i_prev.a;
      r_stage.b     <= i_prev.b;
      r_stage.acc   <= w_acc_next;
    end
  end

  assign o_stage = r_stage;

endmodule

// File: rtl/mul_pipe.sv
// 5-stage unsigned multiply pipeline publishing per-stage hazard/bypass state and retiring to writeback.
// Option macro MUL_EARLY_FWD_EN: full product computed into MUL0 and every live stage is bypassable.
module mul_pipe
  import proc_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ARCH_BITS-1:0]               in_a,
  input  logic [ARCH_BITS-1:0]               in_b,
  input  logic [REG_IDX_BITS-1:0]            in_dst,
  input  logic                               flush,
  output logic [MUL_STAGES-1:0]              st_valid,
  output logic [MUL_STAGES*REG_IDX_BITS-1:0] st_dst,
  output logic [MUL_STAGES-1:0]              st_we,
  output logic [MUL_STAGES*ARCH_BITS-1:0]    st_data,
  output logic                               wb_valid,
  input  logic                               wb_ready,
  output logic [REG_IDX_BITS-1:0]            wb_dst,
  output logic [ARCH_BITS-1:0]               wb_data
);

  mul_stage_t           r_mul0;
  mul_stage_t           w_stage [MUL_STAGES];
  logic                 w_advance;
  logic [ARCH_BITS-1:0] w_mul0_acc;

  // Whole pipe freezes (bubbles included) while the finished op waits for writeback.
  assign w_advance = ~(w_stage[MUL_STAGES-1].valid & ~wb_ready);
  assign in_ready  = w_advance;

`ifdef MUL_EARLY_FWD_EN
  assign w_mul0_acc = in_a * in_b;
`else
  assign w_mul0_acc = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul0 <= '0;
    end else if (flush) begin
      r_mul0.valid <= 1'b0;
    end else if (w_advance) begin
      r_mul0.valid <= in_valid;
      r_mul0.dst   <= in_dst;
      r_mul0.a     <= in_a;
      r_mul0.b     <= in_b;
      r_mul0.acc   <= w_mul0_acc;
    end
  end

  assign w_stage[0] = r_mul0;

  generate
    for (genvar gi = 1; gi < MUL_STAGES; gi++) begin : g_acc
      mul_acc_stage #(.SLICE_IDX(gi)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_advance (w_advance),
        .i_prev    (w_stage[gi-1]),
        .o_stage   (w_stage[gi])
      );
    end

    for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : g_pub
      assign st_valid[gi]                             = w_stage[gi].valid;
      assign st_dst[gi*REG_IDX_BITS +: REG_IDX_BITS]  = w_stage[gi].dst;
      assign st_data[gi*ARCH_BITS +: ARCH_BITS]       = w_stage[gi].acc;
`ifdef MUL_EARLY_FWD_EN
      assign st_we[gi] = w_stage[gi].valid;
`else
      if (gi == MUL_STAGES-1) begin : g_we_last
        assign st_we[gi] = w_stage[gi].valid;
      end else begin : g_we_mid
        assign st_we[gi] = 1'b0;
      end
`endif
    end
  endgenerate

  assign wb_valid = w_stage[MUL_STAGES-1].valid;
  assign wb_dst   = w_stage[MUL_STAGES-1].dst;
  assign wb_data  = w_stage[MUL_STAGES-1].acc;

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: directed scenarios plus randomized traffic against a queue model.
module tb_mul_pipe;
  import proc_pkg::*;

  logic                               clk = 1'b0;
  logic                               rst;
  logic                               in_valid;
  logic                               in_ready;
  logic [ARCH_BITS-1:0]               in_a;
  logic [ARCH_BITS-1:0]               in_b;
  logic [REG_IDX_BITS-1:0]            in_dst;
  logic                               flush;
  logic [MUL_STAGES-1:0]              st_valid;
  logic [MUL_STAGES*REG_IDX_BITS-1:0] st_dst;
  logic [MUL_STAGES-1:0]              st_we;
  logic [MUL_STAGES*ARCH_BITS-1:0]    st_data;
  logic                               wb_valid;
  logic                               wb_ready;
  logic [REG_IDX_BITS-1:0]            wb_dst;
  logic [ARCH_BITS-1:0]               wb_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [REG_IDX_BITS-1:0] dst;
    logic [ARCH_BITS-1:0]    data;
  } exp_t;

  exp_t model_q[$];

  mul_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_dst   (in_dst),
    .flush    (flush),
    .st_valid (st_valid),
    .st_dst   (st_dst),
    .st_we    (st_we),
    .st_data  (st_data),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_dst   (wb_dst),
    .wb_data  (wb_data)
  );

  always #5 clk = ~clk;

  // Low word of the mathematical product.
  function automatic logic [ARCH_BITS-1:0] ref_mul(input logic [ARCH_BITS-1:0] a, input logic [ARCH_BITS-1:0] b);
    logic [2*ARCH_BITS-1:0] p;
    p = {{ARCH_BITS{1'b0}}, a} * {{ARCH_BITS{1'b0}}, b};
    return p[ARCH_BITS-1:0];
  endfunction

  // Which live stages are bypassable in this build.
  function automatic logic [MUL_STAGES-1:0] ref_we(input logic [MUL_STAGES-1:0] v);
`ifdef MUL_EARLY_FWD_EN
    return v;
`else
    return {v[MUL_STAGES-1], {(MUL_STAGES-1){1'b0}}};
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_dst = '0; flush = 1'b0; wb_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (st_valid !== 5'b0) begin failures++; $display("FAIL reset_st_valid got=%b exp=%b", st_valid, 5'b0); end
    checks++;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (st_we !== 5'b0 || st_dst !== '0 || st_data !== '0) begin
      failures++; $display("FAIL reset_st_fields we=%b dst=%h data=%h exp all zero", st_we, st_dst, st_data);
    end
    $display("tb: reset done");
  endtask

  task automatic test_basic();
    logic [MUL_STAGES-1:0] exp_v;
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'd7; in_b = 32'd6; in_dst = 5'd3; wb_ready = 1'b1;
    for (int c = 1; c <= MUL_STAGES; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      exp_v = 5'b1 << (c-1);
      checks++;
      if (st_valid !== exp_v) begin failures++; $display("FAIL basic_st_valid c=%0d got=%b exp=%b", c, st_valid, exp_v); end
      checks++;
      if (st_we !== ref_we(exp_v)) begin failures++; $display("FAIL basic_st_we c=%0d got=%b exp=%b", c, st_we, ref_we(exp_v)); end
      checks++;
      if (wb_valid !== (c == MUL_STAGES)) begin failures++; $display("FAIL basic_wb_valid c=%0d got=%b", c, wb_valid); end
    end
    checks++;
    if (wb_data !== 32'd42 || wb_dst !== 5'd3) begin
      failures++; $display("FAIL basic_result got data=%0d dst=%0d exp data=42 dst=3", wb_data, wb_dst);
    end
    @(negedge clk); #1;
    checks++;
    if (st_valid !== 5'b0) begin failures++; $display("FAIL basic_retired got=%b exp=00000", st_valid); end
    $display("tb: basic 7*6 -> %0d dst=%0d", wb_data, wb_dst);
  endtask

  task automatic test_trunc();
    logic [ARCH_BITS-1:0] av [2];
    logic [ARCH_BITS-1:0] bv [2];
    logic [ARCH_BITS-1:0] ev [2];
    bit seen;
    av[0] = 32'hFFFF_FFFF; bv[0] = 32'hFFFF_FFFF; ev[0] = 32'h0000_0001;
    av[1] = 32'h0001_0000; bv[1] = 32'h0001_0000; ev[1] = 32'h0000_0000;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = av[t]; in_b = bv[t]; in_dst = 5'(t + 10); wb_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (wb_valid) begin
          seen = 1'b1;
          checks++;
          if (wb_data !== ev[t] || wb_data !== ref_mul(av[t], bv[t])) begin
            failures++; $display("FAIL trunc_%0d got=%h exp=%h", t, wb_data, ev[t]);
          end
        end
      end
      if (!seen) begin checks++; failures++; $display("FAIL trunc_timeout_%0d got=no wb_valid exp=result", t); end
      $display("tb: trunc %h*%h -> %h", av[t], bv[t], wb_data);
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (cyc < 280) begin
        in_valid = 1'($urandom_range(0, 1));
        wb_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
        wb_ready = 1'b1;
      end
      in_a = $urandom; in_b = $urandom; in_dst = 5'($urandom);
      #1;
      checks++;
      if ($countones(st_valid) != model_q.size()) begin
        failures++; $display("FAIL rand_occupancy cyc=%0d got=%0d exp=%0d", cyc, $countones(st_valid), model_q.size());
      end
      checks++;
      if (in_ready !== !(wb_valid && !wb_ready)) begin
        failures++; $display("FAIL rand_in_ready cyc=%0d got=%b wb_valid=%b wb_ready=%b", cyc, in_ready, wb_valid, wb_ready);
      end
      if (wb_valid && wb_ready) begin
        checks++;
        if (model_q.size() == 0) begin
          failures++; $display("FAIL rand_spurious_retire cyc=%0d got=data %h exp=none", cyc, wb_data);
        end else begin
          e = model_q.pop_front();
          if (wb_data !== e.data || wb_dst !== e.dst) begin
            failures++; $display("FAIL rand_retire cyc=%0d got=%h/%0d exp=%h/%0d", cyc, wb_data, wb_dst, e.data, e.dst);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.dst = in_dst; e.data = ref_mul(in_a, in_b);
        model_q.push_back(e);
      end
    end
    checks++;
    if (model_q.size() != 0) begin failures++; $display("FAIL rand_drain got=%0d left exp=0", model_q.size()); end
    $display("tb: random traffic complete");
  endtask

  task automatic test_back_to_back();
    exp_t exp_ops [5];
    int n;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_dst = 5'(i + 1); wb_ready = 1'b1;
      exp_ops[i].dst = in_dst; exp_ops[i].data = ref_mul(in_a, in_b);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_issue_ready i=%0d got=%b exp=1", i, in_ready); end
    end
    // Full pipe with writeback blocked; a pending issue must be ignored.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_dst = 5'd31; wb_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0 || st_valid !== 5'b11111) begin
        failures++; $display("FAIL b2b_stall s=%0d got ready=%b valid=%b exp ready=0 valid=11111", s, in_ready, st_valid);
      end
      checks++;
      if (wb_data !== exp_ops[0].data || wb_dst !== exp_ops[0].dst) begin
        failures++; $display("FAIL b2b_hold s=%0d got=%h/%0d exp=%h/%0d", s, wb_data, wb_dst, exp_ops[0].data, exp_ops[0].dst);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; wb_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (wb_valid) begin
        checks++;
        if (n >= 5) begin
          failures++; $display("FAIL b2b_extra got=%h/%0d exp=no more results", wb_data, wb_dst);
        end else if (wb_data !== exp_ops[n].data || wb_dst !== exp_ops[n].dst) begin
          failures++; $display("FAIL b2b_order n=%0d got=%h/%0d exp=%h/%0d", n, wb_data, wb_dst, exp_ops[n].data, exp_ops[n].dst);
        end
        n++;
      end
    end
    checks++;
    if (n != 5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", n); end
    $display("tb: back-to-back retired %0d ops", n);
  endtask

  task automatic test_flush();
    wb_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_a = 32'd3; in_b = 32'd4; in_dst = 5'd7;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_a = 32'd5; in_b = 32'd6; in_dst = 5'd8;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (st_valid !== 5'b01010) begin failures++; $display("FAIL flush_setup got=%b exp=01010", st_valid); end
    flush = 1'b1; in_valid = 1'b1; in_a = 32'd9; in_b = 32'd9; in_dst = 5'd9;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (st_valid !== 5'b0) begin failures++; $display("FAIL flush_clear got=%b exp=00000", st_valid); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      checks++;
      if (wb_valid !== 1'b0 || st_valid !== 5'b0) begin
        failures++; $display("FAIL flush_killed c=%0d got wb_valid=%b st_valid=%b exp 0", c, wb_valid, st_valid);
      end
    end
    $display("tb: flush done");
  endtask

  task automatic test_early();
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'd5; in_b = 32'd9; in_dst = 5'd4; wb_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
`ifdef MUL_EARLY_FWD_EN
    checks++;
    if (st_we[0] !== 1'b1 || st_data[ARCH_BITS-1:0] !== 32'd45) begin
      failures++; $display("FAIL early_fwd got we0=%b data0=%0d exp we0=1 data0=45", st_we[0], st_data[ARCH_BITS-1:0]);
    end
`else
    checks++;
    if (st_we[0] !== 1'b0 || st_valid[0] !== 1'b1 || st_data[ARCH_BITS-1:0] !== 32'd0) begin
      failures++; $display("FAIL early_off got we0=%b v0=%b data0=%0d exp we0=0 v0=1 data0=0", st_we[0], st_valid[0], st_data[ARCH_BITS-1:0]);
    end
`endif
    repeat (6) @(negedge clk);
    $display("tb: early-forward check done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trunc();
    test_random();
    test_back_to_back();
    test_flush();
    test_early();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
